// File: rtl/correlator_frame_decoder.sv
// correlator_frame_decoder
//
// Receive-side frame decoder for the correlator integration-frame stream.
// It takes bytes from a UART receiver and uses line-idle gaps to find the
// frame boundaries. Payload counters are assembled little-endian and pushed,
// with their payload index, into a small output FIFO. The 8-byte trailer is
// then checked against the build parameters.
//
// Optional feature macro: CORRELATOR_FRAME_DECODER_TRAILER_CHECK_EN
//   defined   : trailer bytes are compared; error code 2 can be reported.
//   undefined : trailer bytes are only counted; code 2 never occurs.
//
// Ports
//   clk         in   single clock
//   reset_n     in   asynchronous reset, active low
//   rx_data     in   [7:0] received byte
//   rx_valid    in   one-cycle strobe qualifying rx_data
//   word_data   out  [RESOLUTION-1:0] head-of-FIFO counter value
//   word_index  out  [15:0] payload position of word_data
//   word_valid  out  FIFO not empty
//   word_ready  in   consumer accepts the head word
//   frame_done  out  one-cycle pulse at the end of every frame attempt
//   frame_err   out  [1:0] 0 ok, 1 truncated, 2 trailer mismatch, 3 overrun
//   synced      out  high once the first line-idle gap has been seen
`timescale 1ns/1ps

module correlator_frame_decoder #(
   parameter int unsigned RESOLUTION    = 16,
   parameter int unsigned NUM_INPUTS    = 4,
   parameter int unsigned JITTER_LINES  = 21,
   parameter int unsigned PLL_FREQUENCY = 400000000,
   parameter int unsigned GAP_CYCLES    = 4096,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [RESOLUTION-1:0] word_data,
   output logic [15:0]           word_index,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic                  frame_done,
   output logic [1:0]            frame_err,
   output logic                  synced
);

   localparam int unsigned NUM_WORDS =
      (NUM_INPUTS * (NUM_INPUTS - 1) / 2) * JITTER_LINES + NUM_INPUTS;
   localparam int unsigned BPW     = RESOLUTION / 8;
   localparam int unsigned BIW_W   = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned IDX_W   = 16;
   localparam int unsigned ENTRY_W = RESOLUTION + IDX_W;

   // Elaboration-time parameter sanity checks
   generate
      if (RESOLUTION == 0 || (RESOLUTION % 8) != 0) begin : g_bad_resolution
         $error("RESOLUTION must be a non-zero multiple of 8");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("FIFO_DEPTH must be a power of 2 and at least 2");
      end
      if (GAP_CYCLES < 2) begin : g_bad_gap
         $error("GAP_CYCLES must be at least 2");
      end
      if (PLL_FREQUENCY == 0) begin : g_bad_pll
         $error("PLL_FREQUENCY must be non-zero");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_HUNT    = 2'd0,
      S_IDLE    = 2'd1,
      S_PAYLOAD = 2'd2,
      S_TRAILER = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   state_t                r_state;
   logic [GAP_W-1:0]      r_gap;
   logic [RESOLUTION-1:0] r_asm;
   logic [BIW_W-1:0]      r_biw;
   logic [IDX_W-1:0]      r_widx;
   logic [2:0]            r_tcnt;
   logic                  r_ovr;
   logic                  r_mis;
   logic                  r_frame_done;
   logic [1:0]            r_frame_err;
   logic                  r_synced;

   logic [ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr;
   logic [PTR_W-1:0]      r_rd;
   logic [CNT_W-1:0]      r_count;
   logic                  r_word_valid;
   logic [RESOLUTION-1:0] r_word_data;
   logic [IDX_W-1:0]      r_word_index;

   // ---------------------------------------------------------------------
   // Wires
   // ---------------------------------------------------------------------
   logic                  w_gap_hit;
   logic                  w_in_frame;
   logic                  w_trunc;
   logic                  w_word_last;
   logic                  w_payload_last;
   logic [RESOLUTION-1:0] w_asm_next;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_push_ok;
   logic [ENTRY_W-1:0]    w_push_entry;
   logic [PTR_W-1:0]      w_rd_next;
   logic [CNT_W-1:0]      w_count_next;
   logic [ENTRY_W-1:0]    w_head_next;
   logic                  w_mis_byte;
   logic                  w_mis_now;
   logic [1:0]            w_done_code;

   // Line-idle gap detection: fires once per idle stretch
   assign w_gap_hit = !rx_valid && (r_gap == GAP_W'(GAP_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gap <= '0;
      end else if (rx_valid) begin
         r_gap <= '0;
      end else if (r_gap != GAP_W'(GAP_CYCLES)) begin
         r_gap <= r_gap + GAP_W'(1);
      end
   end

   assign w_in_frame     = (r_state == S_PAYLOAD) || (r_state == S_TRAILER);
   assign w_trunc        = w_gap_hit && w_in_frame;
   assign w_word_last    = (r_biw == BIW_W'(BPW - 1));
   assign w_payload_last = w_word_last && (r_widx == IDX_W'(NUM_WORDS - 1));

   // Little-endian word assembly: each new byte enters at the top
   generate
      if (BPW == 1) begin : g_asm_byte
         assign w_asm_next = rx_data;
      end else begin : g_asm_shift
         assign w_asm_next = {rx_data, r_asm[RESOLUTION-1:8]};
      end
   endgenerate

   // In IDLE the incoming byte is payload byte 0, so IDLE and PAYLOAD share
   // the byte path; counters are always zero on entry to IDLE.
   assign w_push = rx_valid && w_word_last &&
                   ((r_state == S_IDLE) || (r_state == S_PAYLOAD));
   assign w_push_entry = {w_asm_next, r_widx};

`ifdef CORRELATOR_FRAME_DECODER_TRAILER_CHECK_EN
   localparam logic [63:0] TRAILER = {8'h00, 8'(RESOLUTION), 8'(NUM_INPUTS),
                                      8'(JITTER_LINES), 32'(PLL_FREQUENCY)};
   logic [7:0] w_trl_exp;
   assign w_trl_exp  = TRAILER[{r_tcnt, 3'b000} +: 8];
   assign w_mis_byte = (rx_data != w_trl_exp);
`else
   assign w_mis_byte = 1'b0;
`endif

   assign w_mis_now   = r_mis || w_mis_byte;
   // Overrun outranks mismatch
   assign w_done_code = r_ovr ? 2'd3 : (w_mis_now ? 2'd2 : 2'd0);

   // Frame sequencing FSM with registered status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_HUNT;
         r_asm        <= '0;
         r_biw        <= '0;
         r_widx       <= '0;
         r_tcnt       <= '0;
         r_ovr        <= 1'b0;
         r_mis        <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_err  <= 2'd0;
         r_synced     <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_trunc) begin
            // Gap inside a frame: abandon it; pushed words stay in the FIFO
            r_frame_done <= 1'b1;
            r_frame_err  <= 2'd1;
            r_ovr        <= 1'b0;
            r_mis        <= 1'b0;
            r_asm        <= '0;
            r_biw        <= '0;
            r_widx       <= '0;
            r_tcnt       <= '0;
            r_state      <= S_IDLE;
         end else begin
            case (r_state)
               S_HUNT: begin
                  if (w_gap_hit) begin
                     r_state  <= S_IDLE;
                     r_synced <= 1'b1;
                  end
               end
               S_IDLE, S_PAYLOAD: begin
                  if (rx_valid) begin
                     r_asm <= w_asm_next;
                     if (w_push && w_full && !w_pop) begin
                        r_ovr <= 1'b1;
                     end
                     if (w_word_last) begin
                        r_biw <= '0;
                        if (w_payload_last) begin
                           r_widx  <= '0;
                           r_state <= S_TRAILER;
                        end else begin
                           r_widx  <= r_widx + IDX_W'(1);
                           r_state <= S_PAYLOAD;
                        end
                     end else begin
                        r_biw   <= r_biw + BIW_W'(1);
                        r_state <= S_PAYLOAD;
                     end
                  end
               end
               S_TRAILER: begin
                  if (rx_valid) begin
                     if (r_tcnt == 3'd7) begin
                        r_frame_done <= 1'b1;
                        r_frame_err  <= w_done_code;
                        r_ovr        <= 1'b0;
                        r_mis        <= 1'b0;
                        r_tcnt       <= '0;
                        r_state      <= S_IDLE;
                     end else begin
                        r_mis  <= w_mis_now;
                        r_tcnt <= r_tcnt + 3'd1;
                     end
                  end
               end
               default: r_state <= S_HUNT;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output word FIFO with a registered head
   // ---------------------------------------------------------------------
   assign w_pop        = r_word_valid && word_ready;
   assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
   // A pop in the same cycle frees the slot for a push into a full FIFO
   assign w_push_ok    = w_push && (!w_full || w_pop);
   assign w_rd_next    = r_rd + PTR_W'(w_pop);
   assign w_count_next = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
   // Write pointer only meets the next read pointer when the FIFO is
   // (about to be) empty, so the pushed entry becomes the head directly.
   assign w_head_next  = (w_push_ok && (r_wr == w_rd_next)) ? w_push_entry
                                                            : r_mem[w_rd_next];

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr] <= w_push_entry;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr         <= '0;
         r_rd         <= '0;
         r_count      <= '0;
         r_word_valid <= 1'b0;
         r_word_data  <= '0;
         r_word_index <= '0;
      end else begin
         r_wr         <= r_wr + PTR_W'(w_push_ok);
         r_rd         <= w_rd_next;
         r_count      <= w_count_next;
         r_word_valid <= (w_count_next != '0);
         if (w_count_next != '0) begin
            {r_word_data, r_word_index} <= w_head_next;
         end
      end
   end

   assign word_data  = r_word_data;
   assign word_index = r_word_index;
   assign word_valid = r_word_valid;
   assign frame_done = r_frame_done;
   assign frame_err  = r_frame_err;
   assign synced     = r_synced;

endmodule

// File: tb/tb_correlator_frame_decoder.sv
// Testbench for correlator_frame_decoder (default parameters).
// A byte-position reference model with a queue-based FIFO predicts every
// output each cycle; a table of whole-frame scenarios and a few hand-written
// sequences add end-of-scenario checks.
`timescale 1ns/1ps

module tb_correlator_frame_decoder;

   localparam int RES   = 16;
   localparam int NI    = 4;
   localparam int JL    = 21;
   localparam int GAP   = 4096;
   localparam int DEPTH = 4;
   localparam int NW    = (NI * (NI - 1) / 2) * JL + NI;
   localparam int BPW   = RES / 8;
   localparam int PB    = NW * BPW;
   localparam int FB    = PB + 8;
   localparam logic [31:0] PLL_W = 32'd400000000;
`ifdef CORRELATOR_FRAME_DECODER_TRAILER_CHECK_EN
   localparam logic [1:0] MIS_CODE = 2'd2;
`else
   localparam logic [1:0] MIS_CODE = 2'd0;
`endif

   logic           clk;
   logic           reset_n;
   logic [7:0]     rx_data;
   logic           rx_valid;
   logic [RES-1:0] word_data;
   logic [15:0]    word_index;
   logic           word_valid;
   logic           word_ready;
   logic           frame_done;
   logic [1:0]     frame_err;
   logic           synced;

   correlator_frame_decoder dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .word_data  (word_data),
      .word_index (word_index),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .synced     (synced)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [RES-1:0] data;
      logic [15:0]    idx;
   } word_t;

   word_t          m_q[$];
   int             m_idle;
   bit             m_synced;
   int             m_pos;
   bit             m_ovr;
   bit             m_mis;
   logic [RES-1:0] m_cur;
   bit             m_done;
   logic [1:0]     m_err;
   logic [7:0]     trl [8];

   int n_vec, n_bad;
   int n_pop, n_done, n_wv;
   logic [1:0] last_err;

   typedef struct {
      int         kind;      // 0 clean, 1 trailer byte 4 = 20
      int         cut;       // bytes sent
      int         rmode;     // 0 ready low, 1 ready high, 2 random
      logic [1:0] exp_err;
      int         exp_pops;
   } vec_t;
   vec_t tbl [5];

   task automatic model_reset();
      m_q.delete();
      m_idle   = 0;
      m_synced = 0;
      m_pos    = 0;
      m_ovr    = 0;
      m_mis    = 0;
      m_cur    = '0;
      m_done   = 0;
      m_err    = 2'd0;
   endtask

   // One clock of the frame rules, written over the absolute byte position
   task automatic model_step(input logic v, input logic [7:0] d, input logic r);
      bit    gap;
      word_t w;
      gap    = !v && (m_idle == GAP - 1);
      m_done = 0;
      if (m_q.size() > 0 && r) void'(m_q.pop_front());
      if (!m_synced) begin
         if (gap) m_synced = 1;
      end else if (v) begin
         if (m_pos < PB) begin
            m_cur = m_cur | (RES'(d) << (8 * (m_pos % BPW)));
            if (m_pos % BPW == BPW - 1) begin
               w.data = m_cur;
               w.idx  = 16'(m_pos / BPW);
               m_cur  = '0;
               if (m_q.size() < DEPTH) m_q.push_back(w);
               else m_ovr = 1;
            end
            m_pos++;
         end else begin
`ifdef CORRELATOR_FRAME_DECODER_TRAILER_CHECK_EN
            if (d != trl[m_pos - PB]) m_mis = 1;
`endif
            if (m_pos == FB - 1) begin
               m_done = 1;
               m_err  = m_ovr ? 2'd3 : (m_mis ? 2'd2 : 2'd0);
               m_pos  = 0;
               m_ovr  = 0;
               m_mis  = 0;
            end else begin
               m_pos++;
            end
         end
      end else if (gap && m_pos > 0) begin
         m_done = 1;
         m_err  = 2'd1;
         m_pos  = 0;
         m_cur  = '0;
         m_ovr  = 0;
         m_mis  = 0;
      end
      if (v) m_idle = 0;
      else if (m_idle < GAP) m_idle++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("word_valid", 32'(word_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         chk("word_data", 32'(word_data), 32'(m_q[0].data));
         chk("word_index", 32'(word_index), 32'(m_q[0].idx));
      end
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      chk("synced", 32'(synced), 32'(m_synced));
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_word_data"}, 32'(word_data), 32'd0);
      chk({tag, "_word_index"}, 32'(word_index), 32'd0);
      chk({tag, "_word_valid"}, 32'(word_valid), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      chk({tag, "_synced"}, 32'(synced), 32'd0);
   endtask

   // Called at a falling edge; returns at the next falling edge
   task automatic cyc(input logic v, input logic [7:0] d, input logic r);
      rx_valid   = v;
      rx_data    = d;
      word_ready = r;
      if (word_valid && r) n_pop++;
      model_step(v, d, r);
      @(posedge clk);
      #1;
      check_outputs();
      if (word_valid) n_wv++;
      if (frame_done) begin
         n_done++;
         last_err = frame_err;
      end
      @(negedge clk);
   endtask

   function automatic logic pick_ready(input int mode);
      if (mode == 2) return ($urandom_range(0, 3) != 0);
      return (mode == 1);
   endfunction

   task automatic idle(input int n, input int rmode);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, pick_ready(rmode));
   endtask

   // kind 0 clean, 1 trailer byte 4 = 20, 2 random trailer corruption
   task automatic send_frame(input int kind, input int cut, input int rmode, input int gap_max);
      logic [7:0] b [FB];
      int k;
      for (int i = 0; i < PB; i++) b[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) b[PB + i] = trl[i];
      if (kind == 1) b[PB + 4] = 8'd20;
      if (kind == 2) begin
         k = $urandom_range(0, 7);
         b[PB + k] = b[PB + k] ^ 8'($urandom_range(1, 255));
      end
      for (int i = 0; i < cut; i++) begin
         cyc(1'b1, b[i], pick_ready(rmode));
         if (gap_max > 0) idle($urandom_range(0, gap_max), rmode);
      end
   endtask

   initial begin
      n_vec = 0; n_bad = 0; n_pop = 0; n_done = 0; n_wv = 0;
      last_err = 2'd0;
      trl[0] = PLL_W[7:0];
      trl[1] = PLL_W[15:8];
      trl[2] = PLL_W[23:16];
      trl[3] = PLL_W[31:24];
      trl[4] = 8'(JL);
      trl[5] = 8'(NI);
      trl[6] = 8'(RES);
      trl[7] = 8'h00;

      tbl[0] = '{kind: 0, cut: FB,  rmode: 1, exp_err: 2'd0,     exp_pops: NW};
      tbl[1] = '{kind: 1, cut: FB,  rmode: 1, exp_err: MIS_CODE, exp_pops: NW};
      tbl[2] = '{kind: 0, cut: FB,  rmode: 0, exp_err: 2'd3,     exp_pops: DEPTH};
      tbl[3] = '{kind: 0, cut: 101, rmode: 1, exp_err: 2'd1,     exp_pops: 50};
      tbl[4] = '{kind: 0, cut: FB,  rmode: 1, exp_err: 2'd0,     exp_pops: NW};

      reset_n    = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      word_ready = 1'b0;
      model_reset();
      @(negedge clk);
      chk_reset_values("rst");
      @(negedge clk);
      reset_n = 1'b1;

      // Bytes before the first gap are ignored
      n_wv = 0;
      for (int i = 0; i < 40; i++) cyc(1'b1, 8'($urandom), 1'b1);
      idle(GAP + 2, 1);
      chk("hunt_no_words", 32'(n_wv), 32'd0);
      chk("synced_after_gap", 32'(synced), 32'd1);

      // Whole-frame scenarios
      for (int t = 0; t < 5; t++) begin
         n_pop  = 0;
         n_done = 0;
         send_frame(tbl[t].kind, tbl[t].cut, tbl[t].rmode, 0);
         if (tbl[t].cut < FB) idle(GAP + 2, 1);
         else idle(24, 1);
         chk($sformatf("tbl%0d_done_count", t), 32'(n_done), 32'd1);
         chk($sformatf("tbl%0d_err", t), 32'(last_err), 32'(tbl[t].exp_err));
         chk($sformatf("tbl%0d_words", t), 32'(n_pop), 32'(tbl[t].exp_pops));
      end

      // Back-to-back frames with no gap between them
      n_done = 0;
      send_frame(0, FB, 1, 0);
      send_frame(0, FB, 1, 0);
      idle(4, 1);
      chk("b2b_done_count", 32'(n_done), 32'd2);
      chk("b2b_err", 32'(last_err), 32'd0);

      // Reset in the middle of a payload
      send_frame(0, 30, 1, 0);
      reset_n = 1'b0;
      #1;
      chk_reset_values("midrst");
      model_reset();
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      n_wv = 0;
      for (int i = 0; i < 10; i++) cyc(1'b1, 8'($urandom), 1'b1);
      idle(GAP + 2, 1);
      chk("resync_no_words", 32'(n_wv), 32'd0);
      chk("resync_synced", 32'(synced), 32'd1);

      // Randomized traffic: sparse bytes, random ready, random corruption
      for (int f = 0; f < 6; f++) begin
         send_frame(($urandom_range(0, 2) == 0) ? 2 : 0, FB, 2, 2);
         idle($urandom_range(0, 4), 2);
      end
      idle(20, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
